// File: rtl/bus_pkg.sv
// Shared bus definitions: ownership states, arbiter defaults and the bus
// address width, used by the arbiter, the address decoder and the muxes.
package bus_pkg;

    // Bus ownership states; the single state bit doubles as the mux select.
    typedef enum logic {
        ST_M0 = 1'b0,
        ST_M1 = 1'b1
    } bus_state_e;

    // Contended cycles the owner may keep the bus before a forced handover.
    localparam int BUS_MAX_HOLD_DEF = 16;

    // Width of the shared bus address.
    localparam int BUS_ADDR_W = 16;

    // Counter width able to hold 0..max_hold-1, never narrower than one bit.
    function automatic int holdCntWidth(input int maxHold);
        return (maxHold <= 2) ? 1 : $clog2(maxHold);
    endfunction

endpackage

// File: rtl/bus_hold_cnt.sv
// Contention counter for the bus arbiter. Counts consecutive contended
// cycles of the current owner and flags the last cycle it may keep the bus.
module bus_hold_cnt
    import bus_pkg::*;
#(
    parameter int MAX_HOLD = BUS_MAX_HOLD_DEF,
    localparam int CNT_W = holdCntWidth(MAX_HOLD)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] hold_cnt,
    output logic             hold_max
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_atLast;

    assign w_atLast = (r_cnt == CNT_LAST);

    // Clear has priority over increment; the count saturates at its last value
    // so it can never wrap even if the handover were somehow suppressed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && !w_atLast) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign hold_cnt = r_cnt;
    assign hold_max = w_atLast;

endmodule

// File: rtl/bus_arbit.sv
// Two-master bus arbiter. Ownership parks on M0, transfers on release or
// after MAX_HOLD contended cycles, and exactly one grant is high at all times.
module bus_arbit
    import bus_pkg::*;
#(
    parameter int MAX_HOLD = BUS_MAX_HOLD_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic m0_req,
    input  logic m1_req,
    output logic m0_grant,
    output logic m1_grant,
    output logic m_sel,
    output logic bus_req
);

    localparam int CNT_W = holdCntWidth(MAX_HOLD);

    bus_state_e       r_state;
    bus_state_e       w_nextState;
    logic             r_m0Grant;
    logic             r_m1Grant;
    logic             w_contend;
    logic             w_switch;
    logic             w_holdInc;
    logic             w_holdClr;
    logic             w_holdMax;
    logic [CNT_W-1:0] w_holdCnt;

    assign w_contend = m0_req && m1_req;

    // Next owner: release-driven handover, or forced handover once the owner
    // has used up its contended hold; M1 releasing always parks on M0.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_M0: begin
                if ((!m0_req && m1_req) || (w_contend && w_holdMax)) begin
                    w_nextState = ST_M1;
                end
            end
            ST_M1: begin
                if (!m1_req || (w_contend && w_holdMax)) begin
                    w_nextState = ST_M0;
                end
            end
        endcase
    end

    assign w_switch  = (w_nextState != r_state);
    assign w_holdInc = w_contend;
    assign w_holdClr = !w_contend || w_switch;

    bus_hold_cnt #(
        .MAX_HOLD (MAX_HOLD)
    ) u_hold_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .inc      (w_holdInc),
        .clr      (w_holdClr),
        .hold_cnt (w_holdCnt),
        .hold_max (w_holdMax)
    );

    // Ownership FSM with registered grants, so requests never reach the
    // grants combinationally and reset lands straight on M0 ownership.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_M0;
            r_m0Grant <= 1'b1;
            r_m1Grant <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_m0Grant <= (w_nextState == ST_M0);
            r_m1Grant <= (w_nextState == ST_M1);
        end
    end

    assign m0_grant = r_m0Grant;
    assign m1_grant = r_m1Grant;
    assign m_sel    = r_m1Grant;

    // The decoder only sees the owner's request, so a handover cycle where
    // the owner has already dropped its request shows no select.
    assign bus_req = r_m0Grant ? m0_req : m1_req;

    // Sanity checks on ownership and counter range while out of reset.
    a_oneGrant: assert property (@(posedge clk) disable iff (!reset_n)
        (r_m0Grant ^ r_m1Grant));
    a_holdBound: assert property (@(posedge clk) disable iff (!reset_n)
        (w_holdCnt <= CNT_W'(MAX_HOLD - 1)));

endmodule

// File: doc/bus_arbit.md
# bus_arbit

Two-master bus arbiter that decides which master (M0 or M1) owns the shared 16-bit bus each cycle and forwards the owner's request to the bus address decoder as its `m_req`. It sits between the two master ports and the slave-select decode, and is the only block that drives the bus ownership select. Ownership parks on M0. A contention counter forces a handover after a bounded hold so that neither master starves.

## Interface
- `MAX_HOLD`, default 16: number of consecutive contended cycles the current owner may keep the bus before a forced handover. Legal range 2..255.
- `clk` input 1: bus clock; all state updates on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `m0_req` input 1: M0 requests the bus. Held high for the whole transfer.
- `m1_req` input 1: M1 requests the bus. Held high for the whole transfer.
- `m0_grant` output 1: M0 owns the bus. Registered.
- `m1_grant` output 1: M1 owns the bus. Registered.
- `m_sel` output 1: master mux select (0 = M0 drives address/data, 1 = M1). Registered, equal to `m1_grant`.
- `bus_req` output 1: forwarded request to the address decoder = `m0_grant ? m0_req : m1_req`. Combinational from registered grant and live request.

## Operation
- Two-state FSM: `ST_M0` (M0 owns) and `ST_M1` (M1 owns). Encoding is one bit; the state register is the source of `m1_grant`/`m_sel`.
- Exactly one grant is high at all times. There is no idle, no-owner state.
- Transitions from `ST_M0`:
  - to `ST_M1` if `m0_req`=0 and `m1_req`=1;
  - to `ST_M1` if both requests are high and `hold_cnt` = `MAX_HOLD`-1 (forced handover);
  - otherwise stay.
- Transitions from `ST_M1`:
  - to `ST_M0` if `m1_req`=0 (park on M0 regardless of `m0_req`);
  - to `ST_M0` if both requests are high and `hold_cnt` = `MAX_HOLD`-1;
  - otherwise stay.
- `hold_cnt`: internal counter, width `$clog2(MAX_HOLD)`.
  - Increments when the owner's request and the other master's request are both high.
  - Cleared to 0 when there is no contention, and on every state change.
  - Never wraps: the handover fires at `MAX_HOLD`-1, before overflow.
- Simultaneous requests while parked on M0 with `hold_cnt`=0: M0 keeps the bus; no change.
- `bus_req` is 0 whenever the owner is not requesting, even if the other master is requesting. The decoder therefore sees no select during the one handover cycle.

## Timing
- Reset state: `ST_M0`, `m0_grant`=1, `m1_grant`=0, `m_sel`=0, `hold_cnt`=0. `bus_req` then equals `m0_req`.
- Grant latency: a request that causes a transition is sampled at edge N; the new grant is visible after edge N (1 cycle).
- A master may drive the bus only in cycles where its grant is high. A master whose grant drops mid-transfer must hold its request and retry; the arbiter does not buffer the transfer.
- Forced handover: with both requests continuously high, ownership alternates every `MAX_HOLD` cycles.
- Reset asserted mid-transfer: the outputs return to reset values immediately (asynchronously). The counter is cleared. Arbitration resumes on the first edge after `reset_n` rises.
- No combinational path from `m0_req`/`m1_req` to the grants. The only such path is to `bus_req`.

## Structure
- Shared bus package/header `bus_pkg`: state localparams `ST_M0`=1'b0 and `ST_M1`=1'b1, the `MAX_HOLD` default, and the bus address width (16). These are shared with the decoder and the master/slave muxes.
- One sub-module is natural: `bus_hold_cnt`, the contention counter.
  - Inputs: `clk`, `reset_n`, `inc`, `clr`.
  - Output: `hold_cnt`, plus `hold_max` flag = (`hold_cnt` = `MAX_HOLD`-1).
- The FSM and output registers stay in `bus_arbit`.

## Test plan
- Reset, no requests: `m0_grant`=1, `m1_grant`=0, `m_sel`=0, `bus_req`=0. Assert `reset_n` low mid-cycle: the outputs reset without waiting for a clock.
- `m1_req`=1 alone for 5 cycles, then 0: `m1_grant`=1 from the cycle after the first sample. `bus_req`=1 while granted. One cycle after `m1_req` falls, the arbiter returns to `m0_grant`=1.
- M0 owns with `m0_req`=1, then `m1_req` rises (`MAX_HOLD`=4): M0 holds for 4 contended cycles, then `m1_grant`=1. With both held high, ownership alternates every 4 cycles and `hold_cnt` never exceeds 3.
- M1 owns, `m1_req` drops while `m0_req`=0: the bus parks on M0 (`m0_grant`=1) and `bus_req`=0.
- M0 releases and M1 requests in the same cycle: handover to M1 after 1 edge. `bus_req`=0 during the handover cycle. No cycle has both grants high, nor both low.
